dac_stream_sequencer: RTL

Per-frame sample scheduler for the I2S DAC path. On each frame tick from the I2S transmitter, it fetches one stereo pair from one of two audio sources (tone ROM or external stream) over a req/ack handshake. It applies a click-free soft-mute gain ramp and presents the scaled pair to the transmitter's sample-load registers. It also counts fetch faults (source timeout, frame overrun).

---
 rtl/dac_stream_sequencer.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/dac_stream_sequencer.sv
// dac_stream_sequencer: per-frame stereo sample fetch from one of two sources,
// soft-mute gain ramp, and a saturating fault counter for source timeouts and
// frame overruns.
`timescale 1ns/1ps
module dac_stream_sequencer #(
    parameter int DW        = 24,
    parameter int GAIN_W    = 8,
    parameter int RAMP_STEP = 4,
    parameter int TIMEOUT   = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          frame_tick,
    input  logic          mute_toggle,
    input  logic          src_sel,
    output logic          src0_req,
    input  logic          src0_ack,
    input  logic [DW-1:0] src0_left,
    input  logic [DW-1:0] src0_right,
    output logic          src1_req,
    input  logic          src1_ack,
    input  logic [DW-1:0] src1_left,
    input  logic [DW-1:0] src1_right,
    output logic [DW-1:0] out_left,
    output logic [DW-1:0] out_right,
    output logic          out_valid,
    output logic          muted,
    output logic          busy,
    output logic [7:0]    fault_cnt
);

    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam int PW = DW + GAIN_W + 2;
    localparam logic [GAIN_W:0] UNITY    = {1'b1, {GAIN_W{1'b0}}};
    localparam logic [GAIN_W:0] STEP     = (GAIN_W + 1)'(RAMP_STEP);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, SCALE, OUT} state_t;

    // Signed sample times unsigned gain, floored back down by GAIN_W bits.
    // The product cannot exceed the sample magnitude, so truncation is exact.
    function automatic logic [DW-1:0] scale_sample(input logic [DW-1:0] s,
                                                   input logic [GAIN_W:0] g);
        logic signed [PW-1:0] s_ext;
        logic signed [PW-1:0] g_ext;
        logic signed [PW-1:0] prod;
        logic signed [PW-1:0] shifted;
        s_ext   = $signed({{(PW - DW){s[DW-1]}}, s});
        g_ext   = $signed({{(PW - GAIN_W - 1){1'b0}}, g});
        prod    = s_ext * g_ext;
        shifted = prod >>> GAIN_W;
        return shifted[DW-1:0];
    endfunction

    // One ramp step toward silence or unity, clamped at both ends.
    function automatic logic [GAIN_W:0] ramp_gain(input logic [GAIN_W:0] g,
                                                  input logic down);
        if (down) begin
            return (g > STEP) ? g - STEP : '0;
        end
        return (g >= UNITY - STEP) ? UNITY : g + STEP;
    endfunction

    // Saturating add of 0..2 fault events in one cycle.
    function automatic logic [7:0] sat_fault(input logic [7:0] c, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, c} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    state_t          state_q, state_d;
    logic            active_src_q, active_src_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [GAIN_W:0] gain_q, gain_d;
    logic            mute_target_q, mute_target_d;
    logic [DW-1:0]   samp_l_q, samp_l_d;
    logic [DW-1:0]   samp_r_q, samp_r_d;
    logic            src0_req_q, src0_req_d;
    logic            src1_req_q, src1_req_d;
    logic [DW-1:0]   out_left_q, out_left_d;
    logic [DW-1:0]   out_right_q, out_right_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic [7:0]      fault_cnt_q, fault_cnt_d;

    logic            ack_active;
    logic            timeout_evt;
    logic            overrun_evt;

    // Next-state logic for the fetch/scale/output sequence and all counters.
    always_comb begin
        state_d       = state_q;
        active_src_d  = active_src_q;
        timer_d       = timer_q;
        gain_d        = gain_q;
        samp_l_d      = samp_l_q;
        samp_r_d      = samp_r_q;
        src0_req_d    = src0_req_q;
        src1_req_d    = src1_req_q;
        out_left_d    = out_left_q;
        out_right_d   = out_right_q;
        out_valid_d   = 1'b0;
        timeout_evt   = 1'b0;
        mute_target_d = mute_target_q ^ mute_toggle;
        ack_active    = active_src_q ? src1_ack : src0_ack;
        overrun_evt   = frame_tick && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    active_src_d = src_sel;
                    timer_d      = '0;
                    src0_req_d   = ~src_sel;
                    src1_req_d   = src_sel;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (ack_active) begin
                    samp_l_d   = active_src_q ? src1_left  : src0_left;
                    samp_r_d   = active_src_q ? src1_right : src0_right;
                    src0_req_d = 1'b0;
                    src1_req_d = 1'b0;
                    state_d    = SCALE;
                end else if (timer_q == TMO_LAST) begin
                    // Source never answered: play silence for this frame.
                    timeout_evt = 1'b1;
                    samp_l_d    = '0;
                    samp_r_d    = '0;
                    src0_req_d  = 1'b0;
                    src1_req_d  = 1'b0;
                    state_d     = SCALE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            SCALE: begin
                // Scaled pair lands in the output registers as OUT begins.
                out_left_d  = scale_sample(samp_l_q, gain_q);
                out_right_d = scale_sample(samp_r_q, gain_q);
                out_valid_d = 1'b1;
                state_d     = OUT;
            end
            OUT: begin
                // A toggle arriving this very cycle already steers the ramp.
                gain_d  = ramp_gain(gain_q, mute_target_d);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        fault_cnt_d = sat_fault(fault_cnt_q, {1'b0, timeout_evt} + {1'b0, overrun_evt});
    end

    // State and output registers; reset drops requests without a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            active_src_q  <= 1'b0;
            timer_q       <= '0;
            gain_q        <= '0;
            mute_target_q <= 1'b0;
            samp_l_q      <= '0;
            samp_r_q      <= '0;
            src0_req_q    <= 1'b0;
            src1_req_q    <= 1'b0;
            out_left_q    <= '0;
            out_right_q   <= '0;
            out_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            fault_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            active_src_q  <= active_src_d;
            timer_q       <= timer_d;
            gain_q        <= gain_d;
            mute_target_q <= mute_target_d;
            samp_l_q      <= samp_l_d;
            samp_r_q      <= samp_r_d;
            src0_req_q    <= src0_req_d;
            src1_req_q    <= src1_req_d;
            out_left_q    <= out_left_d;
            out_right_q   <= out_right_d;
            out_valid_q   <= out_valid_d;
            busy_q        <= busy_d;
            fault_cnt_q   <= fault_cnt_d;
        end
    end

    assign src0_req  = src0_req_q;
    assign src1_req  = src1_req_q;
    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign fault_cnt = fault_cnt_q;
    assign muted     = mute_target_q && (gain_q == '0);

endmodule
